// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the fetch-stage next-PC logic.
// Contents: control opcodes, branch condition-code enum, flag bit positions
// inside the packed {N, V, Z} flag vector.
package pc_ctrl_pkg;

   // Control-flow opcodes; every other opcode value is a non-control op.
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;
   localparam logic [3:0] OP_PCS = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      NEQ    = 3'b000,
      EQ     = 3'b001,
      GT     = 3'b010,
      LT     = 3'b011,
      GTE    = 3'b100,
      LTE    = 3'b101,
      OVFL   = 3'b110,
      UNCOND = 3'b111
   } cond_code_e;

   // Bit positions of the flags in the packed {N, V, Z} vector.
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

endpackage

// File: rtl/pc_control_branch_cond_eval.sv
// Branch condition evaluator: maps a 3-bit condition code and the {N,V,Z}
// flags to a single "condition holds" bit. Purely combinational.
// Ports: cc_i (condition code), flags_i ({N,V,Z}), cond_o (condition true).
module branch_cond_eval
   import pc_ctrl_pkg::*;
(
   input  logic [2:0] cc_i,
   input  logic [2:0] flags_i,
   output logic       cond_o
);

   logic flag_n;
   logic flag_v;
   logic flag_z;

   assign flag_n = flags_i[FLAG_N];
   assign flag_v = flags_i[FLAG_V];
   assign flag_z = flags_i[FLAG_Z];

   always_comb begin
      cond_o = 1'b0;
      case (cond_code_e'(cc_i))
         NEQ:     cond_o = ~flag_z;
         EQ:      cond_o = flag_z;
         GT:      cond_o = ~flag_z & ~flag_n;
         LT:      cond_o = flag_n;
         // Equal, or strictly greater.
         GTE:     cond_o = flag_z | (~flag_z & ~flag_n);
         LTE:     cond_o = flag_n | flag_z;
         OVFL:    cond_o = flag_v;
         UNCOND:  cond_o = 1'b1;
         default: cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_control.sv
// Next-PC selection for the fetch stage: sequential (+2), PC-relative B,
// register BR, PCS, or hold on halt. PC_out/taken are combinational; only the
// halt flag is registered. Macro PC_CTRL_HALT_LATCH_EN makes HLT sticky until
// rst; without it, halted is a one-cycle registered echo of op==HLT.
// Ports: clk, rst (sync, active-high), PC_in, data (BR target), offset
// (signed word offset), op, C (condition), F ({N,V,Z}); PC_out, taken, halted.
module pc_control
   import pc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] PC_in,
   input  logic [15:0] data,
   input  logic [8:0]  offset,
   input  logic [3:0]  op,
   input  logic [2:0]  C,
   input  logic [2:0]  F,
   output logic [15:0] PC_out,
   output logic        taken,
   output logic        halted
);

   logic        halted_q;
   logic        halted_d;
   logic        cond;
   logic        is_b;
   logic        is_br;
   logic        is_hlt;
   logic [15:0] pc_plus2;
   logic [15:0] branch_disp;
   logic [15:0] b_target;

   branch_cond_eval u_cond (
      .cc_i    (C),
      .flags_i (F),
      .cond_o  (cond)
   );

   assign is_b   = (op == OP_B);
   assign is_br  = (op == OP_BR);
   assign is_hlt = (op == OP_HLT);

   assign pc_plus2 = PC_in + 16'd2;

   // Word offset -> byte displacement: sign-extend bit 8, then shift left 1.
   assign branch_disp = {{6{offset[8]}}, offset, 1'b0};
   assign b_target    = pc_plus2 + branch_disp;

   always_comb begin
      PC_out = pc_plus2;
      if (halted_q || is_hlt) begin
         PC_out = PC_in;
      end else if (is_b && cond) begin
         PC_out = b_target;
      end else if (is_br && cond) begin
         PC_out = data;
      end
   end

   assign taken = (is_b || is_br) && cond && !halted_q;

`ifdef PC_CTRL_HALT_LATCH_EN
   assign halted_d = halted_q | is_hlt;
`else
   assign halted_d = is_hlt;
`endif

   // Reset dominates, even when HLT is presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end

   assign halted = halted_q;

endmodule

// File: tb/tb_pc_control.sv
module tb_pc_control;

   localparam logic [3:0] T_B   = 4'b1100;
   localparam logic [3:0] T_BR  = 4'b1101;
   localparam logic [3:0] T_PCS = 4'b1110;
   localparam logic [3:0] T_HLT = 4'b1111;
   localparam logic [3:0] T_ALU = 4'b0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] PC_in;
   logic [15:0] data;
   logic [8:0]  offset;
   logic [3:0]  op;
   logic [2:0]  C;
   logic [2:0]  F;
   logic [15:0] PC_out;
   logic        taken;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   pc_control dut (
      .clk    (clk),
      .rst    (rst),
      .PC_in  (PC_in),
      .data   (data),
      .offset (offset),
      .op     (op),
      .C      (C),
      .F      (F),
      .PC_out (PC_out),
      .taken  (taken),
      .halted (halted)
   );

   always #5 clk = ~clk;

   // Reference halt flag, advanced on the same edge as the DUT.
   logic m_halt = 1'b0;
   always @(posedge clk) begin
      if (rst)
         m_halt <= 1'b0;
      else
`ifdef PC_CTRL_HALT_LATCH_EN
         m_halt <= m_halt | (op == T_HLT);
`else
         m_halt <= (op == T_HLT);
`endif
   end

   typedef struct {
      logic [15:0] pc;
      logic        tk;
      logic        hl;
      int          id;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  c;
      logic [2:0]  f;
      logic [15:0] pc;
      logic [15:0] dat;
      logic [8:0]  off;
      logic [15:0] epc;
      logic        etk;
   } vec_t;
   vec_t vecs[12];

   function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
      logic n, v, z;
      n = f[2]; v = f[1]; z = f[0];
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return !n || z;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic ref_next(input logic [3:0] o, input logic [2:0] c,
                           input logic [2:0] f, input logic [15:0] pc,
                           input logic [15:0] dat, input logic [8:0] off,
                           input logic h, output logic [15:0] epc,
                           output logic etk);
      int signed soff;
      logic ok;
      soff = (off >= 9'd256) ? int'(off) - 512 : int'(off);
      ok   = ref_cond(c, f);
      etk  = ((o == T_B) || (o == T_BR)) && ok && !h;
      if (h || o == T_HLT)       epc = pc;
      else if (o == T_B && ok)   epc = 16'(int'(pc) + 2 + soff * 2);
      else if (o == T_BR && ok)  epc = dat;
      else                       epc = 16'(int'(pc) + 2);
   endtask

   // Drive one cycle of inputs, push the expectation, then sample at negedge.
   task automatic step(input logic r, input logic [3:0] o, input logic [2:0] c,
                       input logic [2:0] f, input logic [15:0] pc,
                       input logic [15:0] dat, input logic [8:0] off,
                       input logic use_exp, input logic [15:0] xpc,
                       input logic xtk, input int id);
      exp_t e;
      logic [15:0] mpc;
      logic mtk;
      @(posedge clk);
      #1;
      rst = r; op = o; C = c; F = f; PC_in = pc; data = dat; offset = off;
      ref_next(o, c, f, pc, dat, off, m_halt, mpc, mtk);
      e.pc = use_exp ? xpc : mpc;
      e.tk = use_exp ? xtk : mtk;
      e.hl = m_halt;
      e.id = id;
      sb.push_back(e);
      @(negedge clk);
      check_out();
   endtask

   task automatic check_out();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: no expectation queued");
         return;
      end
      e = sb.pop_front();
      if (PC_out !== e.pc) begin
         failures++;
         $display("FAIL pc_out[%0d]: got %h want %h", e.id, PC_out, e.pc);
      end
      checks++;
      if (taken !== e.tk) begin
         failures++;
         $display("FAIL taken[%0d]: got %b want %b", e.id, taken, e.tk);
      end
      checks++;
      if (halted !== e.hl) begin
         failures++;
         $display("FAIL halted[%0d]: got %b want %b", e.id, halted, e.hl);
      end
   endtask

   initial begin
      rst = 1'b1; op = T_ALU; C = 3'd0; F = 3'd0;
      PC_in = 16'd400; data = 16'd0; offset = 9'd0;

      vecs[0]  = '{T_ALU, 3'b000, 3'b000, 16'd400,    16'd0,      9'd0,    16'd402,    1'b0};
      vecs[1]  = '{T_BR,  3'b000, 3'b000, 16'd400,    16'd400,    9'd0,    16'd400,    1'b1};
      vecs[2]  = '{T_BR,  3'b000, 3'b100, 16'd400,    16'd400,    9'd0,    16'd400,    1'b1};
      vecs[3]  = '{T_BR,  3'b000, 3'b001, 16'd400,    16'd400,    9'd0,    16'd402,    1'b0};
      vecs[4]  = '{T_B,   3'b000, 3'b000, 16'd400,    16'd0,      9'd4,    16'd410,    1'b1};
      vecs[5]  = '{T_B,   3'b000, 3'b000, 16'd400,    16'd0,      9'h1FC,  16'd394,    1'b1};
      vecs[6]  = '{T_B,   3'b000, 3'b000, 16'hFFFE,   16'd0,      9'd0,    16'h0000,   1'b1};
      vecs[7]  = '{T_PCS, 3'b000, 3'b100, 16'd400,    16'd0,      9'd0,    16'd402,    1'b0};
      vecs[8]  = '{T_B,   3'b110, 3'b010, 16'd400,    16'd0,      9'd4,    16'd410,    1'b1};
      vecs[9]  = '{T_B,   3'b110, 3'b101, 16'd400,    16'd0,      9'd4,    16'd402,    1'b0};
      vecs[10] = '{T_BR,  3'b111, 3'b000, 16'd400,    16'h1234,   9'd0,    16'h1234,   1'b1};
      vecs[11] = '{T_B,   3'b111, 3'b111, 16'hFFFC,   16'd0,      9'h1FF,  16'hFFFC,   1'b1};

      // Reset: halted cleared, next-PC path live during reset.
      step(1'b1, T_ALU, 3'd0, 3'd0, 16'd400, 16'd0, 9'd0, 1'b1, 16'd402, 1'b0, 100);
      step(1'b1, T_HLT, 3'd0, 3'd0, 16'd400, 16'd0, 9'd0, 1'b1, 16'd400, 1'b0, 101);

      for (int i = 0; i < 12; i++)
         step(1'b0, vecs[i].op, vecs[i].c, vecs[i].f, vecs[i].pc, vecs[i].dat,
              vecs[i].off, 1'b1, vecs[i].epc, vecs[i].etk, i);

      // Condition sweep over every code and flag combination.
      for (int c = 0; c < 8; c++)
         for (int f = 0; f < 8; f++)
            step(1'b0, ((f & 1) != 0) ? T_BR : T_B, 3'(c), 3'(f), 16'd400,
                 16'h1234, 9'd4, 1'b0, 16'd0, 1'b0, 200 + c * 8 + f);

      // Halt: immediate hold, then behaviour after HLT leaves.
      step(1'b0, T_HLT, 3'd7, 3'd0, 16'd400, 16'd0, 9'd0, 1'b1, 16'd400, 1'b0, 300);
      step(1'b0, T_ALU, 3'd0, 3'd0, 16'd400, 16'd0, 9'd0, 1'b1, 16'd400, 1'b0, 301);
`ifdef PC_CTRL_HALT_LATCH_EN
      step(1'b0, T_B,   3'd7, 3'd0, 16'd400, 16'd0, 9'd4, 1'b1, 16'd400, 1'b0, 302);
      step(1'b0, T_ALU, 3'd0, 3'd0, 16'd500, 16'd0, 9'd0, 1'b1, 16'd500, 1'b0, 303);
`else
      step(1'b0, T_B,   3'd7, 3'd0, 16'd400, 16'd0, 9'd4, 1'b1, 16'd410, 1'b1, 302);
      step(1'b0, T_ALU, 3'd0, 3'd0, 16'd500, 16'd0, 9'd0, 1'b1, 16'd502, 1'b0, 303);
`endif
      // Reset with HLT present: reset wins, sequential flow resumes.
      step(1'b0, T_HLT, 3'd0, 3'd0, 16'd400, 16'd0, 9'd0, 1'b0, 16'd0, 1'b0, 304);
      step(1'b1, T_HLT, 3'd0, 3'd0, 16'd400, 16'd0, 9'd0, 1'b0, 16'd0, 1'b0, 305);
      step(1'b0, T_ALU, 3'd0, 3'd0, 16'd400, 16'd0, 9'd0, 1'b1, 16'd402, 1'b0, 306);
      step(1'b0, T_BR,  3'd7, 3'd0, 16'd400, 16'h0BEE, 9'd0, 1'b1, 16'h0BEE, 1'b1, 307);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule
